// File: rtl/gsim_sched.sv
// gsim_sched: sequencing controller for the Gauss-Seidel solver datapath.
// Loads the b vector, issues one row update per row per sweep, stops on the
// sweep limit (or on convergence), then streams the x vector out.
// Optional feature macro: GSIM_SCHED_CONV_EN (early exit on max |delta| <= TOL).
module gsim_sched #(
    parameter int unsigned N        = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned MAX_ITER = 64,
    parameter int unsigned ITER_W   = 7,
    parameter logic [31:0] TOL      = 32'd4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_en,
    output logic              b_we,
    output logic [ADDR_W-1:0] b_waddr,
    output logic              upd_req,
    output logic [ADDR_W-1:0] upd_row,
    output logic [5:0]        upd_nmask,
    input  logic              upd_ack,
    input  logic [31:0]       upd_delta,
    output logic [ADDR_W-1:0] x_raddr,
    input  logic [31:0]       x_rdata,
    output logic              out_valid,
    output logic [31:0]       x_out,
    output logic              busy,
    output logic [ITER_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_CHECK, S_OUT, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N - 1);
    localparam logic [ADDR_W:0]   N_EXT    = (ADDR_W + 1)'(N);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   load_cnt, load_cnt_nxt;
    logic                upd_req_nxt;
    logic [ADDR_W-1:0]   upd_row_nxt;
    logic [5:0]          upd_nmask_nxt;
    logic [ITER_W-1:0]   iter_cnt_nxt;
    logic [ADDR_W-1:0]   x_raddr_nxt;
    logic                raddr_vld, raddr_vld_nxt;
    logic                rd_vld, rd_last, out_last;
    logic                busy_nxt;
    logic                sweep_start;
    logic                conv_hit;

    // Neighbour mask: bit k set when row+offset(k) lies inside 0..N-1
    function automatic logic [5:0] nmask_of(input logic [ADDR_W-1:0] row);
        logic [ADDR_W:0] rw;
        logic [5:0]      m;
        rw   = {1'b0, row};
        m[0] = rw >= (ADDR_W + 1)'(3);
        m[1] = rw >= (ADDR_W + 1)'(2);
        m[2] = rw >= (ADDR_W + 1)'(1);
        m[3] = (rw + (ADDR_W + 1)'(1)) < N_EXT;
        m[4] = (rw + (ADDR_W + 1)'(2)) < N_EXT;
        m[5] = (rw + (ADDR_W + 1)'(3)) < N_EXT;
        return m;
    endfunction

`ifdef GSIM_SCHED_CONV_EN
    logic [31:0] max_delta;

    // Largest |delta| acknowledged during the current sweep
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_delta <= '0;
        end else if (sweep_start) begin
            max_delta <= '0;
        end else if (state == S_ISSUE && upd_req && upd_ack && upd_delta > max_delta) begin
            max_delta <= upd_delta;
        end
    end

    assign conv_hit = (max_delta <= TOL);
`else
    logic unused_delta;
    assign unused_delta = ^upd_delta;
    assign conv_hit     = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            load_cnt  <= '0;
            upd_req   <= 1'b0;
            upd_row   <= '0;
            upd_nmask <= '0;
            iter_cnt  <= '0;
            x_raddr   <= '0;
            raddr_vld <= 1'b0;
            rd_vld    <= 1'b0;
            rd_last   <= 1'b0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            x_out     <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            load_cnt  <= load_cnt_nxt;
            upd_req   <= upd_req_nxt;
            upd_row   <= upd_row_nxt;
            upd_nmask <= upd_nmask_nxt;
            iter_cnt  <= iter_cnt_nxt;
            x_raddr   <= x_raddr_nxt;
            raddr_vld <= raddr_vld_nxt;
            rd_vld    <= raddr_vld;
            rd_last   <= raddr_vld && (x_raddr == LAST_ROW);
            out_last  <= rd_last;
            out_valid <= rd_vld;
            if (rd_vld) begin
                x_out <= x_rdata;
            end
            busy      <= busy_nxt;
        end
    end

    // Next-state, next-register values and the combinational b-memory write port
    always_comb begin
        state_nxt     = state;
        load_cnt_nxt  = load_cnt;
        upd_req_nxt   = upd_req;
        upd_row_nxt   = upd_row;
        iter_cnt_nxt  = iter_cnt;
        x_raddr_nxt   = x_raddr;
        raddr_vld_nxt = 1'b0;
        sweep_start   = 1'b0;
        b_we          = 1'b0;
        b_waddr       = '0;

        unique case (state)
            S_IDLE: begin
                if (in_en) begin
                    b_we         = 1'b1;
                    load_cnt_nxt = ADDR_W'(1);
                    iter_cnt_nxt = '0;
                    if (N == 1) begin
                        sweep_start = 1'b1;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (in_en) begin
                    b_we    = 1'b1;
                    b_waddr = load_cnt;
                    if (load_cnt == LAST_ROW) begin
                        sweep_start = 1'b1;
                    end else begin
                        load_cnt_nxt = load_cnt + ADDR_W'(1);
                    end
                end
            end
            S_ISSUE: begin
                if (upd_req && upd_ack) begin
                    if (upd_row == LAST_ROW) begin
                        upd_req_nxt = 1'b0;
                        state_nxt   = S_CHECK;
                    end else begin
                        upd_row_nxt = upd_row + ADDR_W'(1);
                    end
                end
            end
            S_CHECK: begin
                iter_cnt_nxt = iter_cnt + ITER_W'(1);
                if (iter_cnt_nxt == ITER_W'(MAX_ITER) || conv_hit) begin
                    state_nxt     = S_OUT;
                    x_raddr_nxt   = '0;
                    raddr_vld_nxt = 1'b1;
                end else begin
                    sweep_start = 1'b1;
                end
            end
            S_OUT: begin
                raddr_vld_nxt = raddr_vld && (x_raddr != LAST_ROW);
                if (raddr_vld_nxt) begin
                    x_raddr_nxt = x_raddr + ADDR_W'(1);
                end
                if (out_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (sweep_start) begin
            state_nxt   = S_ISSUE;
            upd_req_nxt = 1'b1;
            upd_row_nxt = '0;
        end

        upd_nmask_nxt = upd_req_nxt ? nmask_of(upd_row_nxt) : 6'b000000;
        busy_nxt      = (state_nxt != S_IDLE);
        b_we          = b_we & reset;
    end

endmodule

// File: tb/tb_gsim_sched.sv
// Scoreboard bench for gsim_sched: b writes, row requests and x output words
// are checked against expectations queued or modelled by the bench.
module tb_gsim_sched;

    localparam int unsigned N    = 16;
    localparam int unsigned AW   = 4;
    localparam int unsigned MAXI = 4;
    localparam int unsigned IW   = 7;
    localparam logic [31:0] TOL  = 32'd4;
`ifdef GSIM_SCHED_CONV_EN
    localparam bit CONV = 1'b1;
`else
    localparam bit CONV = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_en = 1'b0;
    logic          upd_ack = 1'b0;
    logic [31:0]   upd_delta = '0;
    logic [31:0]   x_rdata = '0;
    logic          b_we, upd_req, out_valid, busy;
    logic [AW-1:0] b_waddr, upd_row, x_raddr;
    logic [5:0]    upd_nmask;
    logic [31:0]   x_out;
    logic [IW-1:0] iter_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [31:0]   x_mem [N];
    logic [AW-1:0] exp_waddr_q [$];
    logic [31:0]   exp_x_q [$];

    // responder / monitor state
    int lat = 0, mode = 0, exp_row = 0, sweep = 0, wait_cnt = 0, acks = 0;
    int wr_cnt = 0, out_cnt = 0, first_ov = 0, last_ov = 0;
    bit in_req = 1'b0;

    gsim_sched #(.N(N), .ADDR_W(AW), .MAX_ITER(MAXI), .ITER_W(IW), .TOL(TOL)) dut (
        .clk(clk), .reset(reset), .in_en(in_en),
        .b_we(b_we), .b_waddr(b_waddr),
        .upd_req(upd_req), .upd_row(upd_row), .upd_nmask(upd_nmask),
        .upd_ack(upd_ack), .upd_delta(upd_delta),
        .x_raddr(x_raddr), .x_rdata(x_rdata),
        .out_valid(out_valid), .x_out(x_out),
        .busy(busy), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) x_rdata <= x_mem[x_raddr];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] ref_mask(input int r);
        logic [5:0] m;
        int off;
        for (int k = 0; k < 6; k++) begin
            off  = (k < 3) ? k - 3 : k - 2;
            m[k] = (r + off >= 0) && (r + off < int'(N));
        end
        return m;
    endfunction

    function automatic logic [31:0] delta_fn(input int md, input int sw, input int row);
        case (md)
            1:       return (sw == 0) ? 32'd100 : 32'd4;
            2:       return (sw == 0) ? 32'd100 : ((sw == 1 && row == 5) ? 32'd5 : 32'd0);
            default: return 32'(1000 + row);
        endcase
    endfunction

    function automatic int exp_sweeps(input int md);
        logic [31:0] m;
        for (int s = 0; s < int'(MAXI); s++) begin
            m = '0;
            for (int r = 0; r < int'(N); r++)
                if (delta_fn(md, s, r) > m) m = delta_fn(md, s, r);
            if (CONV && m <= TOL) return s + 1;
        end
        return int'(MAXI);
    endfunction

    // b-memory write monitor
    always @(negedge clk) begin
        if (reset && b_we) begin
            wr_cnt++;
            if (exp_waddr_q.size() == 0) check("b_we_unexpected", 32'(b_we), 32'd0);
            else check("b_waddr", 32'(b_waddr), 32'(exp_waddr_q.pop_front()));
        end
    end

    // x output monitor
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (out_cnt == 0) first_ov = cyc;
            last_ov = cyc;
            out_cnt++;
            if (exp_x_q.size() == 0) check("out_unexpected", 32'(out_valid), 32'd0);
            else check("x_out", x_out, exp_x_q.pop_front());
        end
    end

    // Row-update responder: checks order/mask/hold, acks after lat cycles
    always @(negedge clk) begin
        upd_ack = 1'b0;
        if (!reset) begin
            in_req = 1'b0;
        end else if (upd_req) begin
            if (!in_req) begin
                in_req   = 1'b1;
                wait_cnt = lat;
                check("upd_row", 32'(upd_row), 32'(exp_row));
                check("upd_nmask", 32'(upd_nmask), 32'(ref_mask(exp_row)));
                check("req_after_load", 32'(wr_cnt >= int'(N)), 32'd1);
            end else begin
                check("req_hold_row", 32'(upd_row), 32'(exp_row));
            end
            if (wait_cnt == 0) begin
                upd_ack   = 1'b1;
                upd_delta = delta_fn(mode, sweep, exp_row);
                acks++;
                in_req = 1'b0;
                exp_row++;
                if (exp_row == int'(N)) begin
                    exp_row = 0;
                    sweep++;
                end
            end else begin
                wait_cnt--;
            end
        end
    end

    function automatic logic [31:0] out_vec();
        return 32'({b_we, b_waddr, upd_req, upd_row, upd_nmask, x_raddr, out_valid, busy, iter_cnt});
    endfunction

    task automatic do_load(input bit gapped);
        int n = 0;
        int c = 0;
        while (n < int'(N)) begin
            @(posedge clk); #1;
            if (!gapped || (c % 3 == 0)) begin
                in_en = 1'b1;
                n++;
            end else begin
                in_en = 1'b0;
            end
            c++;
        end
        @(posedge clk); #1;
        in_en = 1'b0;
    endtask

    task automatic arm(input int l, input int md);
        lat = l; mode = md; exp_row = 0; sweep = 0; acks = 0; wr_cnt = 0; out_cnt = 0;
        for (int k = 0; k < int'(N); k++) begin
            exp_waddr_q.push_back(AW'(k));
            exp_x_q.push_back(x_mem[k]);
        end
    endtask

    task automatic run(input int l, input bit gapped, input int md, input bit spurious);
        int exp_sw;
        int t;
        exp_sw = exp_sweeps(md);
        arm(l, md);
        do_load(gapped);
        if (spurious) begin
            repeat (4) begin @(posedge clk); #1; in_en = 1'b1; end
            @(posedge clk); #1;
            in_en = 1'b0;
        end
        t = 0;
        while (busy && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("run_timeout", 32'(t < 5000), 32'd1);
        check("ack_count", 32'(acks), 32'(exp_sw * int'(N)));
        check("iter_cnt", 32'(iter_cnt), 32'(exp_sw));
        check("write_count", 32'(wr_cnt), 32'(N));
        check("out_count", 32'(out_cnt), 32'(N));
        check("out_span", 32'(last_ov - first_ov), 32'(N - 1));
        check("done_to_idle", 32'(cyc - last_ov), 32'd2);
        check("x_left", 32'(exp_x_q.size()), 32'd0);
    endtask

    task automatic reset_mid();
        int t;
        arm(3, 0);
        do_load(1'b0);
        t = 0;
        while (!(upd_req && upd_row == AW'(7)) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("mid_row7_reached", 32'(t < 2000), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_outputs", out_vec(), 32'd0);
        check("rst_mid_x_out", x_out, 32'd0);
        exp_waddr_q.delete();
        exp_x_q.delete();
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < int'(N); k++)
            x_mem[k] = 32'h8000_0001 + 32'(k) * 32'h0101_0101;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", out_vec(), 32'd0);
        check("rst_x_out", x_out, 32'd0);
        #2 reset = 1'b1;
        run(0, 1'b0, 1, 1'b0);
        run(3, 1'b1, 2, 1'b1);
        reset_mid();
        run(0, 1'b0, 0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
